// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store controller
// Purpose : FSM state encoding and default abort limit used by lsu_ctrl.
// Contents: lsu_state_t, LSU_TIMEOUT_DEFAULT, lsu_misaligned().
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } lsu_state_t;

  localparam int LSU_TIMEOUT_DEFAULT = 15;

  // Word accesses only: any nonzero low address bit is a misaligned access.
  function automatic logic lsu_misaligned(input logic [1:0] a_lo);
    return (a_lo != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_busy_timer.sv
// rtl/lsu_busy_timer.sv - saturating wait counter that flags the abort point
// Purpose : counts cycles spent waiting on a busy memory.
// Ports   : clock, reset (async, active-low)
//           clear   - zero the count (entry to ISSUE)
//           enable  - count this cycle (WAIT with mem_busy high)
//           expired - this counting cycle brings the count to TIMEOUT
module lsu_busy_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Saturates at TIMEOUT so it can never wrap back to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Flag the cycle whose increment reaches TIMEOUT, so WAIT lasts exactly
  // TIMEOUT busy cycles before the abort.
  assign expired = enable && (r_cnt == LAST_CNT);

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-cycle-issue load/store unit controller
// Purpose : turns MemRead/MemWrite from the core controller into one memory
//           strobe, waits out mem_busy (with abort), and returns load data.
// Ports   : clock, reset (async, active-low)
//           MemRead, MemWrite, addr, wdata   - request from the core
//           stall, rdata, done, err          - status/result to the core
//           mem_addr, mem_wdata, mem_re, mem_we, mem_rdata, mem_busy - memory
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-1:0] addr,
  input  logic [NBITS-1:0] wdata,
  output logic             stall,
  output logic [NBITS-1:0] rdata,
  output logic             done,
  output logic             err,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  input  logic [NBITS-1:0] mem_rdata,
  input  logic             mem_busy
);

  lsu_state_t       r_state;
  lsu_state_t       w_next_state;
  logic [NBITS-1:0] r_addr;
  logic [NBITS-1:0] r_wdata;
  logic [NBITS-1:0] r_rdata;
  logic             r_is_write;
  logic             r_err;

  logic w_req;
  logic w_misalign;
  logic w_timer_clear;
  logic w_timer_enable;
  logic w_expired;

  assign w_req      = MemRead || MemWrite;
  assign w_misalign = lsu_misaligned(addr[1:0]);

  assign w_timer_clear  = (r_state == ST_IDLE) && w_req && !w_misalign;
  assign w_timer_enable = (r_state == ST_WAIT) && mem_busy;

  lsu_busy_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (w_timer_clear),
    .enable  (w_timer_enable),
    .expired (w_expired)
  );

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_next_state = w_misalign ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (!mem_busy || w_expired) begin
          w_next_state = ST_DONE;
        end
      end
      // Always back to IDLE: a request still held from the finished access
      // must not slip straight into a second ISSUE.
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    stall  = 1'b0;
    done   = 1'b0;
    mem_re = 1'b0;
    mem_we = 1'b0;
    unique case (r_state)
      // Gated by reset so a request held during reset does not stall.
      ST_IDLE:  stall = reset && w_req;
      ST_ISSUE: begin
        stall  = 1'b1;
        mem_re = !r_is_write;
        mem_we = r_is_write;
      end
      ST_WAIT:  stall = 1'b1;
      ST_DONE:  done  = 1'b1;
      default:  stall = 1'b0;
    endcase
  end

  // Request latch, load data and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_req) begin
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_is_write <= MemWrite;   // write wins when both are requested
        if (w_misalign) begin
          r_err <= 1'b1;
        end
      end
      if (r_state == ST_WAIT) begin
        if (!mem_busy) begin
          if (!r_is_write) begin
            r_rdata <= mem_rdata;
          end
        end else if (w_expired) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
    end
  end

  assign rdata     = r_rdata;
  assign err       = r_err;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard testbench for lsu_ctrl
module tb_lsu_ctrl;

  localparam int NB = 8;
  localparam int TO = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic          MemRead, MemWrite;
  logic [NB-1:0] addr, wdata, mem_rdata;
  logic          mem_busy;
  logic          stall, done, err, mem_re, mem_we;
  logic [NB-1:0] rdata, mem_addr, mem_wdata;

  lsu_ctrl #(.NBITS(NB), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_busy  (mem_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [NB-1:0] rdata;
    logic          err;
    int            lat;
    int            kind;   // 0 no strobe, 1 read strobe, 2 write strobe
  } exp_t;

  exp_t          sb_q[$];
  logic [NB-1:0] m_rdata;
  logic          m_err;
  int            n_chk = 0;
  int            n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_access(input logic rd, input logic wr, input logic [NB-1:0] a,
                            input logic [NB-1:0] wd, input logic [NB-1:0] rv,
                            input int busy_n, input bit stuck, input bit hold);
    exp_t e, g;
    int   cyc, n_str, got_kind, busy_left;
    bit   seen_done;
    // Reference model of the expected completion.
    if (a[1:0] != 2'b00) begin
      e.kind = 0; e.lat = 1; m_err = 1'b1;
    end else if (stuck) begin
      e.kind = wr ? 2 : 1; e.lat = 2 + TO; m_err = 1'b1; m_rdata = '0;
    end else begin
      e.kind = wr ? 2 : 1; e.lat = 3 + busy_n;
      if (!wr) m_rdata = rv;
    end
    e.rdata = m_rdata;
    e.err   = m_err;
    sb_q.push_back(e);

    @(negedge clock);
    MemRead = rd; MemWrite = wr; addr = a; wdata = wd; mem_rdata = rv; mem_busy = 1'b0;
    #1 check_val("stall_req", stall, 1);
    cyc = 0; n_str = 0; got_kind = 0; busy_left = 0; seen_done = 0;
    while (!seen_done && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (mem_re || mem_we) begin
        n_str++;
        got_kind = mem_we ? 2 : 1;
        check_val("mem_addr", mem_addr, a);
        if (mem_we) check_val("mem_wdata", mem_wdata, wd);
        busy_left = busy_n + 1;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      mem_busy = stuck || (busy_left > 0);
      if (done) begin
        seen_done = 1;
        g = sb_q.pop_front();
        check_val("latency", cyc, g.lat);
        check_val("rdata", rdata, g.rdata);
        check_val("err", err, g.err);
        check_val("stall_done", stall, 0);
        check_val("strobe_cnt", n_str, (g.kind != 0) ? 1 : 0);
        check_val("strobe_kind", got_kind, g.kind);
      end
    end
    if (!seen_done) begin
      check_val("done_bound", 0, 1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
    mem_busy = 1'b0;
    if (hold) begin
      @(negedge clock);
      check_val("no_retrigger", {mem_re, mem_we, done}, 0);
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clock);
    check_val("done_pulse", done, 0);
  endtask

  initial begin
    logic [NB-1:0] ra;
    reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; addr = 8'h10; wdata = 8'hFF;
    mem_rdata = 8'h00; mem_busy = 1'b0;
    m_rdata = '0; m_err = 1'b0;
    repeat (2) @(negedge clock);
    check_val("rst_outs", {stall, done, err, mem_re, mem_we}, 0);
    check_val("rst_data", {rdata, mem_addr, mem_wdata}, 0);
    MemRead = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    run_access(1, 0, 8'h08, 8'h00, 8'h5A, 0, 0, 0);   // basic read
    run_access(0, 1, 8'h04, 8'h33, 8'hEE, 4, 0, 0);   // write, 4 busy cycles
    run_access(1, 1, 8'h0C, 8'hA5, 8'h11, 1, 0, 1);   // both: write wins, held
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 63)) << 2;
      run_access(1, 0, ra, 8'h00, 8'($urandom), $urandom_range(0, 3), 0, 0);
    end
    run_access(1, 0, 8'h06, 8'h00, 8'h99, 0, 0, 0);   // misaligned

    // Reset in the middle of WAIT.
    @(negedge clock);
    MemRead = 1'b1; addr = 8'h10; mem_rdata = 8'h44; mem_busy = 1'b0;
    @(negedge clock);
    mem_busy = 1'b1;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_val("rst_wait_outs", {stall, done, err, mem_re, mem_we}, 0);
    check_val("rst_wait_data", {rdata, mem_addr, mem_wdata}, 0);
    MemRead = 1'b0; mem_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check_val("rst_no_done", done, 0);
    end
    reset = 1'b1;
    m_err = 1'b0; m_rdata = '0;
    @(negedge clock);

    run_access(1, 0, 8'h20, 8'h00, 8'hC3, 2, 0, 0);   // fresh read after reset
    run_access(1, 0, 8'h24, 8'h00, 8'hBB, 0, 1, 0);   // timeout abort
    run_access(1, 0, 8'h28, 8'h00, 8'h77, 0, 0, 0);   // good read, err sticky

    check_val("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
